// File: rtl/ahb_sram_ctrl_p_if.sv
// ahb_sram_ctrl_p_if: AHB-lite slave bus plus SRAM macro strobes for ahb_sram_ctrl_p.
//  slave modport (controller): bus requests and sram_rdata in; hready_resp/hresp/hrdata and
//  sram_cs_n/sram_we_n/sram_addr/sram_wdata out. master modport is the mirror image.
interface ahb_sram_ctrl_p_if #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8192,
  parameter int NUM_BANKS = 2
);
  localparam int AW = $clog2(DEPTH);
  logic                        hsel;
  logic                        hwrite;
  logic                        hready;
  logic [2:0]                  hsize;
  logic [1:0]                  htrans;
  logic [31:0]                 haddr;
  logic [DATA_W-1:0]           hwdata;
  logic                        hready_resp;
  logic [1:0]                  hresp;
  logic [DATA_W-1:0]           hrdata;
  logic [NUM_BANKS-1:0]        sram_cs_n;
  logic [DATA_W/8-1:0]         sram_we_n;
  logic [AW-1:0]               sram_addr;
  logic [DATA_W-1:0]           sram_wdata;
  logic [NUM_BANKS*DATA_W-1:0] sram_rdata;
  modport slave (
    input  hsel, hwrite, hready, hsize, htrans, haddr, hwdata, sram_rdata,
    output hready_resp, hresp, hrdata, sram_cs_n, sram_we_n, sram_addr, sram_wdata
  );
  modport master (
    output hsel, hwrite, hready, hsize, htrans, haddr, hwdata, sram_rdata,
    input  hready_resp, hresp, hrdata, sram_cs_n, sram_we_n, sram_addr, sram_wdata
  );
endinterface

// File: rtl/ahb_sram_ctrl_p.sv
// ahb_sram_ctrl_p: AHB-lite slave controller for NUM_BANKS banks of single-port SRAM macros.
//  hclk/hreset: clock and async active-high reset. bus (slave modport): AHB address/data
//  phase signals, responses, and the shared SRAM strobes with per-bank chip selects.
module ahb_sram_ctrl_p #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8192,
  parameter int NUM_BANKS = 2,
  parameter int RD_LAT    = 1
) (
  input logic hclk,
  input logic hreset,
  ahb_sram_ctrl_p_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int BW  = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam logic [63:0] LIMIT = 64'(NUM_BANKS) * 64'(DEPTH) * 64'(NB);
  typedef enum logic [2:0] {IDLE, WR, RD, ERR1, ERR2} state_t;
  state_t state, nxt;
  logic [AW-1:0] word_r;
  logic [BW-1:0] bank_r, bank_d;
  logic [NB-1:0] mask_r, lanes;
  logic [1:0] cnt;
  logic [7:0] amsk;
  logic acc, err, rd_last, done, issue;
  always_comb begin
    acc = bus.hsel & bus.hready & bus.htrans[1];
    amsk = (8'd1 << bus.hsize) - 8'd1;
    err = ({32'b0, bus.haddr} >= LIMIT) | (bus.hsize > 3'(OFF)) | (|(bus.haddr[7:0] & amsk));
    // lane count is 2^hsize; oversize transfers are errors so only hsize[1:0] matters here
    lanes = NB'(((16'd1 << (5'd1 << bus.hsize[1:0])) - 16'd1) << bus.haddr[OFF-1:0]);
    bank_d = NUM_BANKS > 1 ? bus.haddr[OFF+AW +: BW] : '0;
    rd_last = state == RD && cnt == 2'(RD_LAT);
    // cycles in which the current data phase ends and a new address phase may be taken
    done = state == IDLE || state == WR || state == ERR2 || rd_last;
    issue = state == WR || (state == RD && cnt == 2'd0);
    nxt = state;
    if (done) nxt = !acc ? IDLE : err ? ERR1 : bus.hwrite ? WR : RD;
    else if (state == ERR1) nxt = ERR2;
    bus.hready_resp = !(state == ERR1 || (state == RD && !rd_last));
    bus.hresp = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
    bus.hrdata = rd_last ? bus.sram_rdata[bank_r*DATA_W +: DATA_W] : '0;
    bus.sram_cs_n = issue ? ~(NUM_BANKS'(1) << bank_r) : '1;
    bus.sram_we_n = state == WR ? ~mask_r : '1;
    bus.sram_addr = (state == WR || state == RD) ? word_r : '0;
    bus.sram_wdata = state == WR ? bus.hwdata : '0;
  end
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      word_r <= '0;
      bank_r <= '0;
      mask_r <= '0;
      cnt <= '0;
    end else begin
      cnt <= (state == RD && !rd_last) ? cnt + 2'd1 : 2'd0;
      if (done && acc) begin
        word_r <= bus.haddr[OFF +: AW];
        bank_r <= bank_d;
        mask_r <= lanes;
      end
    end
endmodule

// File: tb/tb_ahb_sram_ctrl_p.sv
// tb_ahb_sram_ctrl_p: scoreboard bench with byte-level reference memory and SRAM macro models.
module tb_ahb_sram_ctrl_p;
  localparam int DATA_W = 32, DEPTH = 8192, NUM_BANKS = 2, RD_LAT = 2;
  logic hclk = 0, hreset = 0;
  always #5 hclk = ~hclk;
  ahb_sram_ctrl_p_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS)) bus();
  assign bus.hready = bus.hready_resp;
  ahb_sram_ctrl_p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .RD_LAT(RD_LAT)) dut (
    .hclk(hclk), .hreset(hreset), .bus(bus));
  typedef struct packed {
    logic err; logic wr; logic [31:0] rdata; logic [31:0] wdata;
    logic [1:0] cs_n; logic [3:0] we_n; logic [12:0] addr;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int n_chk = 0, n_fail = 0;
  logic [7:0] refm [65536];
  logic [31:0] pend = 0;
  logic [31:0] wm;
  assign wm = {{8{~bus.sram_we_n[3]}}, {8{~bus.sram_we_n[2]}}, {8{~bus.sram_we_n[1]}}, {8{~bus.sram_we_n[0]}}};
  for (genvar g = 0; g < NUM_BANKS; g++) begin : bk
    logic [31:0] mem [DEPTH];
    logic [31:0] p0 = 0, p1 = 0;
    always @(posedge hclk) begin
      p1 <= p0;
      if (!bus.sram_cs_n[g] && &bus.sram_we_n) p0 <= mem[bus.sram_addr];
      if (!bus.sram_cs_n[g] && !(&bus.sram_we_n))
        mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~wm) | (bus.sram_wdata & wm);
    end
    assign bus.sram_rdata[g*32 +: 32] = p1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_resp"}, {bus.hready_resp, bus.hresp, bus.hrdata}, {1'b1, 2'b00, 32'h0});
    chk({nm, "_sram"}, {bus.sram_cs_n, bus.sram_we_n, bus.sram_addr, bus.sram_wdata},
        {2'b11, 4'hF, 13'h0, 32'h0});
  endtask
  task automatic push(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n, lo;
    logic [31:0] base;
    n = 1 << sz;
    lo = int'(a % 4);
    base = a & ~32'h3;
    e = '0;
    e.err = a >= 32'h10000 || sz > 3'd2 || (a % (32'd1 << sz)) != 0;
    e.wr = w;
    e.wdata = d;
    e.cs_n = (a / 32'h8000) == 0 ? 2'b10 : 2'b01;
    e.addr = 13'((a / 4) % DEPTH);
    e.we_n = 4'hF;
    if (!e.err && w)
      for (int k = 0; k < n; k++) begin
        e.we_n[lo+k] = 1'b0;
        refm[a+k] = d[8*(lo+k) +: 8];
      end
    if (!e.err) e.rdata = {refm[base+3], refm[base+2], refm[base+1], refm[base]};
    exp_q.push_back(e);
  endtask
  task automatic xfer(input logic sel, input logic w, input logic [1:0] tr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    int t;
    logic r;
    t = 0;
    bus.hsel = sel; bus.hwrite = w; bus.htrans = tr; bus.hsize = sz; bus.haddr = a; bus.hwdata = pend;
    do begin
      @(negedge hclk);
      r = bus.hready_resp;
      @(posedge hclk);
      #1;
      t++;
    end while (!r && t < 20);
    if (!r) begin
      n_chk++; n_fail++;
      $display("FAIL xfer_timeout: hready_resp low for %0d cycles, required high", t);
      summary();
      $fatal(1);
    end
    pend = d;
    if (sel && tr[1]) push(w, sz, a, d);
  endtask
  logic dph = 0, first = 0, bad = 0;
  int waits = 0;
  initial forever begin
    @(negedge hclk);
    if (hreset) begin
      dph = 0;
      exp_q.delete();
    end else begin
      if (!dph)
        chk("idle_resp", {bus.hready_resp, bus.hresp, bus.hrdata, bus.sram_cs_n, bus.sram_we_n},
            {1'b1, 2'b00, 32'h0, 2'b11, 4'hF});
      else begin
        if (first) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty: data phase with no expected entry at %0t", $time);
            cur = '0;
          end else cur = exp_q.pop_front();
          if (!cur.err)
            chk("issue_strobe", {bus.sram_cs_n, bus.sram_we_n, bus.sram_addr}, {cur.cs_n, cur.we_n, cur.addr});
        end
        if ((!first || cur.err) && bus.sram_cs_n != 2'b11) bad = 1;
        if (!bus.hready_resp && (bus.hrdata != 0 || bus.hresp != (cur.err ? 2'b01 : 2'b00))) bad = 1;
        first = 0;
        if (!bus.hready_resp) waits++;
        else begin
          chk("hresp", bus.hresp, cur.err ? 2'b01 : 2'b00);
          chk("wait_states", waits, cur.err ? 1 : cur.wr ? 0 : RD_LAT);
          chk("quiet_wait", bad, 0);
          if (!cur.err && cur.wr) chk("wdata", bus.sram_wdata, cur.wdata);
          if (!cur.err && !cur.wr) chk("hrdata", bus.hrdata, cur.rdata);
          dph = 0;
        end
      end
      if (bus.hready_resp && bus.hsel && bus.htrans[1]) begin
        dph = 1; first = 1; waits = 0; bad = 0;
      end
    end
  end
  initial begin
    #500000;
    n_chk++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    int r;
    bus.hsel = 0; bus.hwrite = 0; bus.htrans = 0; bus.hsize = 0; bus.haddr = 0; bus.hwdata = 0;
    for (int i = 0; i < 65536; i++) refm[i] = 8'h0;
    #1 hreset = 1;
    #1 chk_reset("reset_init");
    repeat (2) @(posedge hclk);
    #1 hreset = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) xfer(1, 1, 2'b10, 3'd2, b * 32'h8000 + i * 4, 32'h0);
    xfer(1, 1, 2'b10, 3'd2, 32'h4, 32'hDEADBEEF);
    xfer(1, 0, 2'b10, 3'd2, 32'h4, 32'h0);
    xfer(0, 0, 2'b00, 3'd0, 32'h0, 32'h0);
    xfer(1, 1, 2'b10, 3'd0, 32'h6, 32'h00AA0000);
    xfer(1, 0, 2'b10, 3'd2, 32'h4, 32'h0);
    xfer(1, 1, 2'b11, 3'd2, 32'h8000, 32'h12345678);
    xfer(1, 0, 2'b10, 3'd2, 32'h0, 32'h0);
    xfer(1, 0, 2'b10, 3'd2, 32'h8000, 32'h0);
    xfer(1, 0, 2'b10, 3'd2, 32'h10000, 32'h0);
    xfer(1, 0, 2'b10, 3'd1, 32'h1, 32'h0);
    xfer(1, 1, 2'b10, 3'd3, 32'h0, 32'h0);
    xfer(1, 0, 2'b01, 3'd2, 32'h4, 32'h0);
    xfer(1, 1, 2'b10, 3'd1, 32'h8002, 32'hBEEF0000);
    xfer(1, 0, 2'b10, 3'd2, 32'h8000, 32'h0);
    repeat (400) begin
      r = int'($urandom_range(0, 9));
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (r == 0) a = 32'h10000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom | 32'h10000;
      else a = $urandom_range(0, 1) * 32'h8000 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      xfer($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), sz, a, $urandom);
    end
    xfer(0, 0, 2'b00, 3'd0, 32'h0, 32'h0);
    chk("drained", exp_q.size(), 0);
    hreset = 1;
    #1 chk_reset("reset_idle");
    @(posedge hclk);
    #1 hreset = 0;
    xfer(1, 1, 2'b10, 3'd2, 32'h8010, 32'hCAFEF00D);
    xfer(1, 0, 2'b10, 3'd2, 32'h8010, 32'h0);
    hreset = 1;
    bus.hsel = 0; bus.htrans = 2'b00; bus.hwdata = 0;
    pend = 0;
    #1 chk_reset("reset_mid_read");
    @(posedge hclk);
    #1 hreset = 0;
    xfer(1, 0, 2'b10, 3'd2, 32'h8010, 32'h0);
    xfer(0, 0, 2'b00, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge hclk);
    chk("final_drained", exp_q.size(), 0);
    summary();
    $finish;
  end
endmodule
